alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 103 ++++++++++
 tb/tb_alu_result_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Elastic output stage for a 64-bit ALU: buffers result words in a small FIFO
// and accumulates chain-wide zero and carry state across multi-word operations.
module alu_result_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_s,
  input  logic        in_cout,
  input  logic [1:0]  in_op,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_s,
  output logic [1:0]  out_op,
  output logic        out_c,
  output logic        out_z,
  output logic        out_n,
  output logic        out_last,
  output logic        carry_fb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [63:0] s;
    logic [1:0]  op;
    logic        c;
    logic        z;
    logic        last;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            zacc_q, zacc_d;
  logic            carry_fb_q, carry_fb_d;
  logic            push, pop, word_z;
  entry_t          head;

  // in_ready is a flop, so a pop never opens the input in the same cycle.
  assign push   = in_valid && in_ready_q;
  assign pop    = out_valid_q && out_ready;
  assign word_z = (in_s == 64'd0) && zacc_q;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    zacc_d     = zacc_q;
    carry_fb_d = carry_fb_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{s: in_s, op: in_op, c: in_cout, z: word_z, last: in_last};
      wr_ptr_d        = PW'(wr_ptr_q + 1'b1);
      zacc_d          = in_last ? 1'b1 : word_z;
      carry_fb_d      = in_last ? 1'b0 : in_cout;
    end
    if (pop) rd_ptr_d = PW'(rd_ptr_q + 1'b1);
    count_d     = count_q + CW'(push) - CW'(pop);
    in_ready_d  = (count_d < CW'(DEPTH));
    out_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      zacc_q      <= 1'b1;
      carry_fb_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      zacc_q      <= zacc_d;
      carry_fb_q  <= carry_fb_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_s     = head.s;
  assign out_op    = head.op;
  assign out_c     = head.c;
  assign out_z     = head.z;
  assign out_n     = head.s[63];
  assign out_last  = head.last;
  assign carry_fb  = carry_fb_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alu_result_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_cout, in_last;
  logic [63:0] in_s;
  logic [1:0]  in_op;
  logic        out_valid, out_ready;
  logic [63:0] out_s;
  logic [1:0]  out_op;
  logic        out_c, out_z, out_n, out_last, carry_fb;

  int checks = 0;
  int errors = 0;

  alu_result_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_cout(in_cout), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_op(out_op), .out_c(out_c), .out_z(out_z), .out_n(out_n),
    .out_last(out_last), .carry_fb(carry_fb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of expected words and the chain state.
  typedef struct {
    logic [63:0] s;
    logic [1:0]  op;
    logic        c;
    logic        z;
    logic        last;
  } exp_t;

  exp_t q[$];
  logic m_zacc = 1'b1;
  logic m_cf   = 1'b0;
  bit   m_on   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_zacc = 1'b1;
      m_cf   = 1'b0;
      m_on   = 1'b1;
    end else if (m_on) begin
      int  sz;
      bit  do_pop, do_push;
      exp_t e;
      sz      = q.size();
      do_pop  = (sz != 0) && out_ready;
      do_push = in_valid && (sz < DEPTH);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.s = in_s; e.op = in_op; e.c = in_cout; e.last = in_last;
        e.z = (in_s == 64'd0) && m_zacc;
        q.push_back(e);
        m_zacc = in_last ? 1'b1 : e.z;
        m_cf   = in_last ? 1'b0 : in_cout;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on && !rst) begin
      chk("m_in_ready", in_ready, q.size() < DEPTH);
      chk("m_out_valid", out_valid, q.size() != 0);
      chk("m_carry_fb", carry_fb, m_cf);
      if (q.size() != 0) begin
        chk("m_out_s", out_s, q[0].s);
        chk("m_out_op", out_op, q[0].op);
        chk("m_out_c", out_c, q[0].c);
        chk("m_out_z", out_z, q[0].z);
        chk("m_out_n", out_n, q[0].s[63]);
        chk("m_out_last", out_last, q[0].last);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] s, input logic c,
                       input logic [1:0] op, input logic last);
    in_valid = v; in_s = s; in_cout = c; in_op = op; in_last = last;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 2'd0, 1'b1);
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_s", out_s, 64'd0);
    chk("rst_flags", {out_op, out_c, out_z, out_n, out_last, carry_fb}, 7'd0);

    // Single word
    out_ready = 1'b1;
    drive(1'b1, 64'd0, 1'b1, 2'd2, 1'b1);
    #1 chk("sw_no_same_cycle", out_valid, 1'b0);
    cyc();
    drive(1'b0, 64'd0, 1'b0, 2'd0, 1'b1);
    chk("sw_valid", out_valid, 1'b1);
    chk("sw_flags", {out_z, out_c, out_op, out_n, carry_fb}, 6'b11_1000);
    cyc();
    chk("sw_drained", out_valid, 1'b0);

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 64'h1, 1'b0, 2'd1, 1'b1); cyc();
    chk("bp_ready_after_1", in_ready, 1'b1);
    drive(1'b1, 64'h2, 1'b0, 2'd1, 1'b1); cyc();
    chk("bp_full", in_ready, 1'b0);
    drive(1'b1, 64'h3, 1'b0, 2'd1, 1'b1); cyc();
    chk("bp_hold_s", out_s, 64'h1);
    drive(1'b0, 64'h0, 1'b0, 2'd0, 1'b1);
    out_ready = 1'b1;
    #1 chk("bp_no_comb_ready", in_ready, 1'b0);
    cyc();
    chk("bp_second", out_s, 64'h2);
    chk("bp_ready_back", in_ready, 1'b1);
    cyc();
    chk("bp_empty", out_valid, 1'b0);

    // Two-word chains
    drive(1'b1, 64'h0, 1'b1, 2'd0, 1'b0); cyc();
    chk("ch0_carry_fb", carry_fb, 1'b1);
    chk("ch0_z", out_z, 1'b1);
    drive(1'b1, 64'h0, 1'b0, 2'd0, 1'b1); cyc();
    chk("ch0_w1_z", out_z, 1'b1);
    chk("ch0_w1_last", out_last, 1'b1);
    chk("ch0_carry_clr", carry_fb, 1'b0);
    drive(1'b1, 64'h5, 1'b1, 2'd0, 1'b0); cyc();
    chk("ch1_w0_z", out_z, 1'b0);
    drive(1'b1, 64'h0, 1'b0, 2'd0, 1'b1); cyc();
    chk("ch1_w1_z", out_z, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 2'd0, 1'b1); cyc();

    // Simultaneous push and pop
    out_ready = 1'b0;
    drive(1'b1, 64'hA, 1'b0, 2'd3, 1'b1); cyc();
    out_ready = 1'b1;
    drive(1'b1, 64'hB, 1'b0, 2'd3, 1'b1); cyc();
    chk("sim_valid", out_valid, 1'b1);
    chk("sim_s", out_s, 64'hB);
    out_ready = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 2'd0, 1'b1); cyc();
    chk("sim_stable", out_s, 64'hB);
    out_ready = 1'b1; cyc();
    chk("sim_empty", out_valid, 1'b0);

    // Reset mid-chain
    out_ready = 1'b0;
    drive(1'b1, 64'h7, 1'b1, 2'd0, 1'b0); cyc();
    drive(1'b1, 64'h0, 1'b1, 2'd0, 1'b0); cyc();
    chk("rmc_carry_fb", carry_fb, 1'b1);
    rst = 1'b1;
    drive(1'b1, 64'h9, 1'b1, 2'd1, 1'b0); cyc();
    rst = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 2'd0, 1'b1);
    chk("rmc_valid", out_valid, 1'b0);
    chk("rmc_cf", carry_fb, 1'b0);
    chk("rmc_ready", in_ready, 1'b1);
    chk("rmc_out_s", out_s, 64'd0);
    out_ready = 1'b1;
    drive(1'b1, 64'h0, 1'b0, 2'd0, 1'b1); cyc();
    chk("rmc_fresh_z", out_z, 1'b1);

    // Negative flag
    drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 2'd1, 1'b1); cyc();
    chk("neg_n", out_n, 1'b1);
    chk("neg_z", out_z, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 2'd0, 1'b1); cyc();

    // Mixed traffic checked by the model
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom},
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 2) == 0));
      out_ready = 1'($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 60) == 0);
      cyc();
    end
    rst = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 2'd0, 1'b1);
    out_ready = 1'b1;
    repeat (DEPTH + 2) cyc();
    chk("final_empty", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
